// File: rtl/run_checker_pkg.sv
// run_checker_pkg: FSM state encoding and width helper shared by the CPU run checker.
package run_checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_checker_cmp.sv
// run_checker_cmp: selects probe/expected channel idx and reports equality and mask skip.
module run_checker_cmp
    import run_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CHECKS = 4,
    parameter int IW         = idx_width(NUM_CHECKS)
) (
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0] probe_values,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0] expected_values,
    input  logic [NUM_CHECKS-1:0]            check_mask,
    input  logic [IW-1:0]                    idx,
    output logic                             match,
    output logic                             skip
);

    always_comb begin
        match = 1'b0;
        skip  = 1'b1;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (idx == k[IW-1:0]) begin
                match = probe_values[k*DATA_WIDTH +: DATA_WIDTH] == expected_values[k*DATA_WIDTH +: DATA_WIDTH];
                skip  = !check_mask[k];
            end
        end
    end

endmodule

// File: rtl/cpu_run_checker.sv
// cpu_run_checker: resets a CPU, runs it to halt or timeout, then checks probe channels.
// Define RUN_CHECKER_ERR_COUNT_EN to check every channel and expose an err_count output.
module cpu_run_checker
    import run_checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 250
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   halt_i,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]       probe_values,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]       expected_values,
    input  logic [NUM_CHECKS-1:0]                  check_mask,
    output logic                                   dut_rst,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   pass,
    output logic                                   fail,
    output logic                                   timeout,
    output logic [idx_width(NUM_CHECKS)-1:0]       fail_index,
`ifdef RUN_CHECKER_ERR_COUNT_EN
    output logic [$clog2(NUM_CHECKS+1)-1:0]        err_count,
`endif
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]    cycle_count
);

    localparam int IW = idx_width(NUM_CHECKS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = idx_width(RESET_CYCLES);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_CHECKS - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RESET_CYCLES - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [IW-1:0] idx_q, idx_d, fail_index_q, fail_index_d;
    logic [CW-1:0] cycle_count_q, cycle_count_d;
    logic          dut_rst_q, dut_rst_d, busy_q, busy_d, done_q, done_d;
    logic          pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic          match, skip;
`ifdef RUN_CHECKER_ERR_COUNT_EN
    localparam int EW = $clog2(NUM_CHECKS + 1);
    logic [EW-1:0] err_q, err_d;
`endif

    run_checker_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_CHECKS(NUM_CHECKS),
        .IW        (IW)
    ) u_cmp (
        .probe_values   (probe_values),
        .expected_values(expected_values),
        .check_mask     (check_mask),
        .idx            (idx_q),
        .match          (match),
        .skip           (skip)
    );

    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        idx_d         = idx_q;
        cycle_count_d = cycle_count_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        fail_index_d  = fail_index_q;
`ifdef RUN_CHECKER_ERR_COUNT_EN
        err_d         = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RESET;
                    rcnt_d       = '0;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                    timeout_d    = 1'b0;
                    fail_index_d = '0;
`ifdef RUN_CHECKER_ERR_COUNT_EN
                    err_d        = '0;
`endif
                end
            end
            S_RESET: begin
                if (rcnt_q == R_LAST) begin
                    state_d       = S_RUN;
                    cycle_count_d = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Halt takes priority over a timeout landing in the same cycle.
                if (halt_i) begin
                    state_d = S_CHECK;
                    idx_d   = '0;
                end else if (cycle_count_q == T_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                end else begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
            end
            S_CHECK: begin
`ifdef RUN_CHECKER_ERR_COUNT_EN
                if (!skip && !match) begin
                    err_d  = err_q + 1'b1;
                    fail_d = 1'b1;
                    if (!fail_q) fail_index_d = idx_q;
                end
                if (idx_q == I_LAST) begin
                    pass_d  = !fail_d;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
`else
                if (!skip && !match) begin
                    fail_d       = 1'b1;
                    fail_index_d = idx_q;
                    state_d      = S_DONE;
                end else if (idx_q == I_LAST) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        dut_rst_d = state_d inside {S_IDLE, S_RESET};
        busy_d    = state_d inside {S_RESET, S_RUN, S_CHECK};
        done_d    = state_d == S_DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rcnt_q        <= '0;
            idx_q         <= '0;
            cycle_count_q <= '0;
            fail_index_q  <= '0;
            dut_rst_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef RUN_CHECKER_ERR_COUNT_EN
            err_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            idx_q         <= idx_d;
            cycle_count_q <= cycle_count_d;
            fail_index_q  <= fail_index_d;
            dut_rst_q     <= dut_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
`ifdef RUN_CHECKER_ERR_COUNT_EN
            err_q         <= err_d;
`endif
        end
    end

    assign dut_rst     = dut_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign fail_index  = fail_index_q;
    assign cycle_count = cycle_count_q;
`ifdef RUN_CHECKER_ERR_COUNT_EN
    assign err_count   = err_q;
`endif

endmodule

// File: tb/tb_cpu_run_checker.sv
// tb_cpu_run_checker: directed checks of cpu_run_checker; u_d has a long timeout, u_t a 16-cycle one.
module tb_cpu_run_checker;

`ifdef RUN_CHECKER_ERR_COUNT_EN
    localparam int MM_LAT = 4;
    localparam int M0_LAT = 4;
`else
    localparam int MM_LAT = 3;
    localparam int M0_LAT = 1;
`endif

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, halt = 1'b0;
    logic [127:0] probe, expv;
    logic [3:0]   mask;
    logic         d_dut_rst, d_busy, d_done, d_pass, d_fail, d_timeout;
    logic         t_dut_rst, t_busy, t_done, t_pass, t_fail, t_timeout;
    logic [1:0]   d_fidx, t_fidx;
    logic [7:0]   d_cc;
    logic [4:0]   t_cc;
`ifdef RUN_CHECKER_ERR_COUNT_EN
    logic [2:0]   d_err, t_err;
`endif
    int           n_chk = 0, n_bad = 0, n;

    always #5 clk = ~clk;

    cpu_run_checker #(.DATA_WIDTH(32), .NUM_CHECKS(4), .RESET_CYCLES(2), .TIMEOUT_CYCLES(250)) u_d (
        .clk(clk), .rst(rst), .start(start), .halt_i(halt),
        .probe_values(probe), .expected_values(expv), .check_mask(mask),
        .dut_rst(d_dut_rst), .busy(d_busy), .done(d_done), .pass(d_pass), .fail(d_fail),
        .timeout(d_timeout), .fail_index(d_fidx),
`ifdef RUN_CHECKER_ERR_COUNT_EN
        .err_count(d_err),
`endif
        .cycle_count(d_cc)
    );

    cpu_run_checker #(.DATA_WIDTH(32), .NUM_CHECKS(4), .RESET_CYCLES(2), .TIMEOUT_CYCLES(16)) u_t (
        .clk(clk), .rst(rst), .start(start), .halt_i(halt),
        .probe_values(probe), .expected_values(expv), .check_mask(mask),
        .dut_rst(t_dut_rst), .busy(t_busy), .done(t_done), .pass(t_pass), .fail(t_fail),
        .timeout(t_timeout), .fail_index(t_fidx),
`ifdef RUN_CHECKER_ERR_COUNT_EN
        .err_count(t_err),
`endif
        .cycle_count(t_cc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] p, input logic [31:0] e);
        probe[c*32 +: 32] = p;
        expv[c*32 +: 32]  = e;
    endtask

    task automatic golden;
        for (int c = 0; c < 4; c++) set_ch(c, 32'h1000_0000 + c * 32'h11, 32'h1000_0000 + c * 32'h11);
        mask = 4'b1111;
    endtask

    // Pulse start, return the number of edges dut_rst of u_d stayed high afterwards.
    task automatic kick(output int hi);
        start = 1'b1;
        tick;
        start = 1'b0;
        hi = 0;
        while (d_dut_rst && hi < 10) begin
            hi++;
            tick;
        end
    endtask

    task automatic wait_d_cc(input int v);
        for (int i = 0; i < 300 && !(!d_dut_rst && d_busy && d_cc == 8'(v)); i++) tick;
        check("d_reach_cc", {63'd0, !d_dut_rst && d_cc == 8'(v)}, 64'd1);
    endtask

    task automatic halt_then_done(output int lat);
        halt = 1'b1;
        tick;
        halt = 1'b0;
        lat = 1;
        while (!d_done && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    initial begin
        golden();
        repeat (3) tick;
        check("rst_dut_rst", d_dut_rst, 1);
        check("rst_busy", d_busy, 0);
        check("rst_done", d_done, 0);
        check("rst_cc", d_cc, 0);
        check("rst_flags", {d_pass, d_fail, d_timeout}, 0);
        rst = 1'b1;
        tick;

        // Clean run with halt at cycle 20; a start pulse mid-RUN must be ignored.
        kick(n);
        check("reset_len", n, 2);
        wait_d_cc(10);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_ignored_cc", d_cc, 11);
        check("start_ignored_rst", d_dut_rst, 0);
        wait_d_cc(20);
        halt_then_done(n);
        check("pass_latency", n, 5);
        check("pass_pass", d_pass, 1);
        check("pass_fail", d_fail, 0);
        check("pass_cc", d_cc, 20);
        check("pass_done_outs", {d_busy, d_dut_rst, d_timeout}, 0);

        // Channel 2 mismatch, also exercises re-run from DONE.
        set_ch(2, 32'h0000_0005, 32'h0000_0006);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("rerun_cleared", {d_pass, d_fail, d_done, d_dut_rst}, 4'b0001);
        for (int i = 0; i < 5 && d_dut_rst; i++) tick;
        wait_d_cc(3);
        halt = 1'b1;
        tick;
        halt = 1'b0;
        n = 0;
        while (!d_done && n < 20) begin
            tick;
            n++;
        end
        check("mm_latency", n, MM_LAT);
        check("mm_fail", {d_pass, d_fail}, 2'b01);
        check("mm_index", d_fidx, 2);
`ifdef RUN_CHECKER_ERR_COUNT_EN
        check("mm_err_count", d_err, 1);
`endif

        // Same mismatch masked off.
        mask = 4'b1011;
        kick(n);
        wait_d_cc(4);
        halt_then_done(n);
        check("mask_latency", n, 5);
        check("mask_pass", {d_pass, d_fail}, 2'b10);

        // Mismatches on 0 and 2: first one reported.
        mask = 4'b1111;
        set_ch(0, 32'hDEAD_BEEF, 32'hDEAD_BEEE);
        kick(n);
        wait_d_cc(2);
        halt_then_done(n);
        check("first_latency", n, M0_LAT + 1);
        check("first_index", d_fidx, 0);
        check("first_fail", {d_pass, d_fail}, 2'b01);

        // MSB-only mismatch on channel 1.
        golden();
        set_ch(1, 32'h8000_0011, 32'h0000_0011);
        kick(n);
        wait_d_cc(1);
        halt_then_done(n);
        check("msb_index", d_fidx, 1);
        check("msb_fail", {d_pass, d_fail}, 2'b01);

        // Timeout on u_t with halt never raised.
        golden();
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!t_done && n < 40) begin
            tick;
            n++;
        end
        check("to_latency", n, 18);
        check("to_flags", {t_timeout, t_fail, t_pass}, 3'b110);
        check("to_cc", t_cc, 15);
        check("to_dut_rst", t_dut_rst, 0);

        // Halt in the timeout cycle wins.
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 40 && !(!t_dut_rst && t_cc == 5'd15); i++) tick;
        check("tie_reach", {t_dut_rst, t_cc}, {1'b0, 5'd15});
        halt = 1'b1;
        tick;
        halt = 1'b0;
        check("tie_in_check", {t_busy, t_done, t_timeout}, 3'b100);
        for (int i = 0; i < 10 && !t_done; i++) tick;
        check("tie_result", {t_done, t_pass, t_fail, t_timeout}, 4'b1100);
        check("tie_cc", t_cc, 15);

        // Reset asserted mid-RUN acts immediately; halt is then ignored in IDLE.
        kick(n);
        wait_d_cc(5);
        rst = 1'b0;
        #1;
        check("async_dut_rst", d_dut_rst, 1);
        check("async_busy_cc", {d_busy, d_cc}, 0);
        tick;
        rst = 1'b1;
        halt = 1'b1;
        tick;
        tick;
        halt = 1'b0;
        check("idle_halt_ignored", {d_busy, d_done, d_dut_rst}, 3'b001);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
